// File: rtl/maxpool_relu_bwd.sv
// Max-pool + ReLU backward router: collects one window of activations, then
// emits the upstream gradient at the winning (largest non-negative) position and zeros elsewhere.
//
// state  | meaning
// S_ACT  | collect WINDOW activations, track running winner
// S_GRAD | await the pooled-output gradient
// S_OUT  | emit WINDOW routed gradient words
module maxpool_relu_bwd #(
    parameter int WINDOW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        act_valid,
    output logic        act_ready,
    input  logic [31:0] act_data,
    input  logic        grad_valid,
    output logic        grad_ready,
    input  logic [31:0] grad_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_idx,
    output logic        out_last
);

    localparam logic [3:0] LAST_POS = 4'(WINDOW - 1);

    typedef enum logic [1:0] {
        S_ACT  = 2'd0,
        S_GRAD = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [30:0] win_mag_q, win_mag_d;
    logic [3:0]  win_idx_q, win_idx_d;
    logic        found_q, found_d;
    logic [31:0] grad_q, grad_d;
    logic        act_pos;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_mag_d = win_mag_q;
        win_idx_d = win_idx_q;
        found_d   = found_q;
        grad_d    = grad_q;
        act_pos   = ~act_data[31];
        case (state_q)
            S_ACT: begin
                if (act_valid) begin
                    if (cnt_q == 4'd0) begin
                        win_mag_d = act_data[30:0];
                        win_idx_d = 4'd0;
                        found_d   = act_pos;
                    // A stored negative winner never blocks a non-negative newcomer; ties go to the later position.
                    end else if (act_pos && (!found_q || act_data[30:0] >= win_mag_q)) begin
                        win_mag_d = act_data[30:0];
                        win_idx_d = cnt_q;
                        found_d   = 1'b1;
                    end
                    if (cnt_q == LAST_POS) begin
                        cnt_d   = 4'd0;
                        state_d = S_GRAD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_GRAD: begin
                if (grad_valid) begin
                    grad_d  = grad_data;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (cnt_q == LAST_POS) begin
                        cnt_d   = 4'd0;
                        state_d = S_ACT;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_ACT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_ACT;
            cnt_q     <= 4'd0;
            win_mag_q <= 31'd0;
            win_idx_q <= 4'd0;
            found_q   <= 1'b0;
            grad_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_mag_q <= win_mag_d;
            win_idx_q <= win_idx_d;
            found_q   <= found_d;
            grad_q    <= grad_d;
        end
    end

    // Outputs are pure decodes of flops, so they cannot change while a stalled word waits.
    assign act_ready  = (state_q == S_ACT);
    assign grad_ready = (state_q == S_GRAD);
    assign out_valid  = (state_q == S_OUT);
    assign out_idx    = out_valid ? cnt_q : 4'd0;
    assign out_last   = out_valid && (cnt_q == LAST_POS);
    assign out_data   = (out_valid && found_q && cnt_q == win_idx_q) ? grad_q : 32'd0;

endmodule

// File: tb/tb_maxpool_relu_bwd.sv
// Self-checking bench for maxpool_relu_bwd: directed windows plus randomized
// windows compared against a max/argmax reference model.
module tb_maxpool_relu_bwd;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        act_valid;
    logic        act_ready;
    logic [31:0] act_data;
    logic        grad_valid;
    logic        grad_ready;
    logic [31:0] grad_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    maxpool_relu_bwd #(.WINDOW(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .act_valid  (act_valid),
        .act_ready  (act_ready),
        .act_data   (act_data),
        .grad_valid (grad_valid),
        .grad_ready (grad_ready),
        .grad_data  (grad_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: gradient goes to the last position holding the largest
    // magnitude among activations whose sign bit is clear; -1 if none.
    function automatic int ref_route(input logic [31:0] a [W]);
        int          best = -1;
        logic [30:0] best_mag = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i][31] == 1'b0 && (best < 0 || a[i][30:0] >= best_mag)) begin
                best     = i;
                best_mag = a[i][30:0];
            end
        end
        return best;
    endfunction

    task automatic send_act(input logic [31:0] d);
        int n = 0;
        act_valid = 1'b1;
        act_data  = d;
        while (!act_ready && n < 50) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        chk("act_ready", {31'd0, act_ready}, 32'd1);
        chk("grad_ready_in_act", {31'd0, grad_ready}, 32'd0);
        chk("out_valid_in_act", {31'd0, out_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        act_valid = 1'b0;
    endtask

    task automatic send_grad(input logic [31:0] g);
        int n = 0;
        grad_valid = 1'b1;
        grad_data  = g;
        while (!grad_ready && n < 50) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        chk("grad_ready", {31'd0, grad_ready}, 32'd1);
        chk("act_ready_in_grad", {31'd0, act_ready}, 32'd0);
        @(posedge clk); @(negedge clk);
        grad_valid = 1'b0;
        chk("out_valid_latency1", {31'd0, out_valid}, 32'd1);
    endtask

    // stall_mode: 0 none, 1 out_ready 1,0,0,1,0,0,..., 2 random stalls.
    // Junk is offered on act/grad throughout to prove those channels stay closed.
    task automatic recv_window(input int ridx, input logic [31:0] g, input int stall_mode);
        logic [31:0] exp_d;
        int          stalls;
        act_valid  = 1'b1;
        grad_valid = 1'b1;
        for (int i = 0; i < W; i++) begin
            int n = 0;
            exp_d  = (i == ridx) ? g : 32'd0;
            stalls = (stall_mode == 1) ? ((i == 0) ? 0 : 2)
                   : (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            act_data  = $urandom;
            grad_data = $urandom;
            while (!out_valid && n < 50) begin
                @(posedge clk); @(negedge clk);
                n++;
            end
            for (int s = 0; s <= stalls; s++) begin
                out_ready = (s == stalls);
                chk("out_valid", {31'd0, out_valid}, 32'd1);
                chk("out_idx", {28'd0, out_idx}, i);
                chk("out_data", out_data, exp_d);
                chk("out_last", {31'd0, out_last}, (i == W - 1) ? 32'd1 : 32'd0);
                chk("act_ready_in_out", {31'd0, act_ready}, 32'd0);
                chk("grad_ready_in_out", {31'd0, grad_ready}, 32'd0);
                @(posedge clk); @(negedge clk);
            end
        end
        out_ready  = 1'b0;
        act_valid  = 1'b0;
        grad_valid = 1'b0;
        chk("act_ready_after_last", {31'd0, act_ready}, 32'd1);
        chk("out_valid_after_last", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_window(input logic [31:0] a [W], input logic [31:0] g, input int stall_mode);
        for (int i = 0; i < W; i++) begin
            send_act(a[i]);
            if (stall_mode == 2) repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        send_grad(g);
        recv_window(ref_route(a), g, stall_mode);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_act_ready"}, {31'd0, act_ready}, 32'd1);
        chk({tag, "_grad_ready"}, {31'd0, grad_ready}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_out_idx"}, {28'd0, out_idx}, 32'd0);
        chk({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    endtask

    initial begin
        logic [31:0] a [W];
        logic [31:0] base [W];

        reset      = 1'b1;
        act_valid  = 1'b0;
        act_data   = '0;
        grad_valid = 1'b0;
        grad_data  = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_idle("reset");

        base = '{32'd5, 32'd9, 32'd3, 32'd7};
        run_window(base, 32'h0000_00AA, 0);

        a = '{32'h8000_0010, 32'd2, 32'h8000_0001, 32'd2};
        run_window(a, 32'h1234_5678, 0);

        a = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0003, 32'h8000_0004};
        run_window(a, 32'd55, 0);

        a = '{32'h8000_0005, 32'd0, 32'h8000_0007, 32'h8000_0001};
        run_window(a, 32'd11, 0);

        a = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        run_window(a, 32'hDEAD_BEEF, 0);

        run_window(base, 32'h0000_00AA, 1);

        // Reset after two activations, with a handshake offered on the reset edge.
        send_act(32'd100);
        send_act(32'd200);
        act_valid = 1'b1;
        act_data  = 32'd300;
        pulse_reset();
        act_valid = 1'b0;
        check_idle("reset_mid_act");
        run_window(base, 32'h0000_00AA, 0);

        // Reset in the middle of the output phase.
        a = '{32'd1, 32'd50, 32'd2, 32'd3};
        for (int i = 0; i < W; i++) send_act(a[i]);
        send_grad(32'h0BAD_F00D);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        pulse_reset();
        check_idle("reset_mid_out");
        run_window(base, 32'h0000_00AA, 0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < W; i++) begin
                logic        neg;
                logic [30:0] mag;
                neg  = ($urandom_range(0, 2) == 0) || (t % 7 == 3);
                mag  = (t % 2 == 0) ? 31'($urandom_range(0, 7)) : 31'($urandom);
                a[i] = {neg, mag};
            end
            run_window(a, $urandom, t % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/maxpool_relu_bwd.md
MAXPOOL_RELU_BWD -- requirements
Module: maxpool_relu_bwd

Interface
REQ-001 Parameter: WINDOW, default 4, number of activations per pooling window; legal range 2..16.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock domain.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: act_valid  input  1  activation word offered.
REQ-005 Port: act_ready  output  1  block accepts activation word.
REQ-006 Port: act_data  input  32  activation; bit 31 sign, bits 30:0 magnitude.
REQ-007 Port: grad_valid  input  1  upstream gradient word offered.
REQ-008 Port: grad_ready  output  1  block accepts gradient word.
REQ-009 Port: grad_data  input  32  gradient of pooled output; opaque 32-bit value.
REQ-010 Port: out_valid  output  1  routed gradient word valid.
REQ-011 Port: out_ready  input  1  downstream accepts routed word.
REQ-012 Port: out_data  output  32  routed gradient for one window position.
REQ-013 Port: out_idx  output  4  window position of out_data, 0..WINDOW-1.
REQ-014 Port: out_last  output  1  high with the final word (out_idx = WINDOW-1) of a window.

Function
REQ-015 Transfer on any channel SHALL occur only on a rising edge where valid and ready are both high.
REQ-016 FSM SHALL have three states: S_ACT (collect activations), S_GRAD (await gradient), S_OUT (emit routed words).
REQ-017 act_ready SHALL be 1 only in S_ACT; grad_ready only in S_GRAD; out_valid only in S_OUT; all three driven from registered state.
REQ-018 S_ACT SHALL count accepted activations 0..WINDOW-1; on acceptance of position WINDOW-1, next state S_GRAD and counter clears.
REQ-019 Running winner comparison, with running winner W and incoming A: W non-negative and A non-negative -> A wins only if A[30:0] >= W[30:0] (tie -> later position); exactly one non-negative -> it wins; both negative -> no winner.
REQ-020 Position 0 SHALL initialise W and winner index; found flag = NOT act_data[31].
REQ-021 Sign bit 1 SHALL be treated as negative regardless of magnitude (32'h8000_0000 is negative); sign 0 with magnitude 0 is non-negative and can win.
REQ-022 found flag SHALL record whether any activation in the window had sign 0.
REQ-023 S_GRAD: on gradient acceptance, grad_data SHALL be latched, next state S_OUT.
REQ-024 S_OUT SHALL emit WINDOW words, out_idx 0..WINDOW-1 ascending, one per handshake.
REQ-025 out_data SHALL equal latched gradient when found=1 and out_idx = winner index, else 32'h0000_0000.
REQ-026 First out_valid SHALL be asserted in the cycle after gradient acceptance (latency 1); back-to-back words with out_ready held high.
REQ-027 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-028 On handshake of out_last word, next state S_ACT; next window may be accepted the following cycle.
REQ-029 Inputs on a channel whose ready is 0 SHALL be ignored; no channel SHALL be accepted out of its state.
REQ-030 Counter and index widths SHALL be 4 bits; no wrap beyond WINDOW-1.

Reset
REQ-031 reset high at a clock edge SHALL force state S_ACT, counters 0, found 0, winner index 0, latched gradient 0.
REQ-032 During and after reset: act_ready=1 (after release), grad_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0.
REQ-033 Reset asserted mid-window or mid-output SHALL discard partial window and pending outputs; reset SHALL override any simultaneous handshake.

Verification
REQ-034 Acts 5, 9, 3, 7; grad 32'h0000_00AA -> out 0, AA, 0, 0 with idx 0..3, out_last on idx 3.
REQ-035 Acts 32'h8000_0010, 2, 32'h8000_0001, 2 (tie) -> grad routed to idx 3 only.
REQ-036 Acts all negative (32'h8000_0001..32'h8000_0004); grad 55 -> four zero words.
REQ-037 Acts 32'h8000_0005, 0, 32'h8000_0007, 32'h8000_0001; grad 11 -> 11 at idx 1 (+0 wins).
REQ-038 REQ-034 stimulus with out_ready toggled 1,0,0,1,... -> outputs stable during stalls, same sequence, grad_ready/act_ready low throughout S_OUT.
REQ-039 reset pulsed after 2 activations, then full REQ-034 window -> results identical to REQ-034; no stale output.
